// File: rtl/alu_seq_unit.sv
// Execute stage: ALU-control decode, one-cycle ALU ops and iterative MUL/DIV
// behind valid/ready handshakes on both the operand and result sides.
module alu_seq_unit #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruction,
  input  logic [ALUOP_W-1:0] aluop_in,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               zero,
  output logic               div_zero,
  output logic               illegal
);

  localparam int CW = $clog2(XLEN);
  localparam logic [ALUOP_W-1:0] AOP_R  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AOP_LS = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AOP_BR = ALUOP_W'(3);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_MUL, OP_DIV, OP_DZ, OP_ILL
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d, dec_op;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d, res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d, vld_q, vld_d;
  logic            zero_q, zero_d, dz_q, dz_d;
  logic            ill_q, ill_d;

  logic [9:0]      fn;
  logic [XLEN-1:0] exec_res, mul_acc, quo, fin_val;
  logic [XLEN:0]   rem_sh, diff;
  logic            qbit;

  logic unused_instr;
  assign unused_instr = ^{instruction[24:15], instruction[11:0]};

  assign fn = {instruction[31:25], instruction[14:12]};

  always_comb begin
    dec_op = OP_ILL;
    unique case (1'b1)
      (aluop_in == AOP_LS): dec_op = OP_ADD;
      (aluop_in == AOP_BR): dec_op = OP_SUB;
      (aluop_in == AOP_R): begin
        case (fn)
          10'b0000000_000: dec_op = OP_ADD;
          10'b0100000_000: dec_op = OP_SUB;
          10'b0000000_111: dec_op = OP_AND;
          10'b0000000_110: dec_op = OP_OR;
          10'b0000000_010: dec_op = OP_SLT;
          10'b0000001_000: dec_op = OP_MUL;
          10'b0000001_100: dec_op = OP_DIV;
          default:         dec_op = OP_ILL;
        endcase
      end
      default: dec_op = OP_ILL;
    endcase
  end

  always_comb begin
    exec_res = '0;
    case (op_q)
      OP_ADD: exec_res = a_q + b_q;
      OP_SUB: exec_res = a_q - b_q;
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_SLT: exec_res = {{(XLEN-1){1'b0}},
                          $signed(a_q) < $signed(b_q)};
      OP_DZ:  exec_res = '1;
      default: exec_res = '0;
    endcase
  end

  // Divide reuses a_q as dividend/quotient shifter and acc_q as remainder.
  assign mul_acc = b_q[0] ? acc_q + a_q : acc_q;
  assign rem_sh  = {acc_q, a_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign qbit    = ~diff[XLEN];
  assign quo     = {a_q[XLEN-2:0], qbit};
  assign fin_val = (state_q == S_MUL) ? mul_acc
                 : (neg_q ? -quo : quo);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    vld_d   = vld_q;
    res_d   = res_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = op_a;
          b_d     = op_b;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = 1'b0;
          op_d    = dec_op;
          state_d = S_EXEC;
          if (dec_op == OP_MUL) state_d = S_MUL;
          if (dec_op == OP_DIV) begin
            if (op_b == '0) begin
              op_d = OP_DZ;
            end else begin
              state_d = S_DIV;
              a_d   = op_a[XLEN-1] ? -op_a : op_a;
              b_d   = op_b[XLEN-1] ? -op_b : op_b;
              neg_d = op_a[XLEN-1] ^ op_b[XLEN-1];
            end
          end
        end
      end
      S_EXEC: begin
        res_d   = exec_res;
        zero_d  = (exec_res == '0);
        dz_d    = (op_q == OP_DZ);
        ill_d   = (op_q == OP_ILL);
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == S_MUL) begin
          acc_d = mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          a_d   = quo;
        end
        if (cnt_q == CNT_LAST) begin
          res_d   = fin_val;
          zero_d  = (fin_val == '0);
          dz_d    = 1'b0;
          ill_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          res_d   = '0;
          zero_d  = 1'b0;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = vld_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign div_zero  = dz_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised and directed bench for alu_seq_unit against an
// arithmetic reference model.
module tb_alu_seq_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, zero, div_zero, illegal;
  logic [31:0] instruction = '0;
  logic [2:0]  aluop_in = '0;
  logic [31:0] op_a = '0, op_b = '0, result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.XLEN(XLEN), .ALUOP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .aluop_in(aluop_in),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero),
    .div_zero(div_zero), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [2:0]  aop,
    input  logic [6:0]  f7,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        dz,
    output logic        ill,
    output int          lat);
    logic [9:0] fn;
    fn  = {f7, f3};
    r   = '0;
    dz  = 1'b0;
    ill = 1'b0;
    lat = 2;
    if (aop == 3'b010) r = a + b;
    else if (aop == 3'b011) r = a - b;
    else if (aop != 3'b000) ill = 1'b1;
    else begin
      case (fn)
        10'b0000000_000: r = a + b;
        10'b0100000_000: r = a - b;
        10'b0000000_111: r = a & b;
        10'b0000000_110: r = a | b;
        10'b0000000_010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        10'b0000001_000: begin r = a * b; lat = XLEN + 1; end
        10'b0000001_100: begin
          if (b == 0) begin
            r = '1; dz = 1'b1;
          end else begin
            lat = XLEN + 1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = $signed(a) / $signed(b);
          end
        end
        default: ill = 1'b1;
      endcase
    end
  endfunction

  task automatic run_op(input string tag, input logic [2:0] aop,
                        input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] er;
    logic        edz, eill;
    int          elat, edges;
    model(aop, f7, f3, a, b, er, edz, eill, elat);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid    = 1'b1;
    aluop_in    = aop;
    instruction = {f7, 10'($urandom), f3, 12'($urandom)};
    op_a        = a;
    op_b        = b;
    out_ready   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    aluop_in = 3'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    edges    = 1;
    chk({tag, ".in_ready_busy"}, in_ready, 0);
    while (!out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, ".latency"}, edges, elat);
    repeat (hold) @(negedge clk);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".result"}, result, er);
    chk({tag, ".zero"}, zero, (er == 0) ? 1 : 0);
    chk({tag, ".div_zero"}, div_zero, edz);
    chk({tag, ".illegal"}, illegal, eill);
    chk({tag, ".in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".released"}, out_valid, 0);
    chk({tag, ".flags_clr"}, {div_zero, illegal}, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 20)) - 32'd10;
      1: return 32'd0;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  aop;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int          k;

    #12;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out", {out_valid, zero, div_zero, illegal}, 0);
    chk("rst.result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel.in_ready", in_ready, 1);

    run_op("add", 3'b000, 7'h00, 3'b000, 32'd5, 32'd7, 0);
    run_op("br", 3'b011, 7'h55, 3'b101, 32'h1234, 32'h1234, 0);
    run_op("slt", 3'b000, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 1);
    run_op("ld", 3'b010, 7'h7F, 3'b111, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("mul", 3'b000, 7'h01, 3'b000, 32'hFFFF_FFFF, 32'd3, 0);
    run_op("div", 3'b000, 7'h01, 3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div0", 3'b000, 7'h01, 3'b100, 32'd9, 32'd0, 2);
    run_op("divmin", 3'b000, 7'h01, 3'b100, 32'h8000_0000,
           32'hFFFF_FFFF, 0);
    run_op("ill", 3'b111, 7'h00, 3'b000, 32'd3, 32'd4, 5);
    run_op("illf", 3'b000, 7'h20, 3'b111, 32'd3, 32'd4, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    in_valid    = 1'b1;
    aluop_in    = 3'b000;
    instruction = {7'h01, 10'd0, 3'b100, 12'd0};
    op_a        = 32'd1000;
    op_b        = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid.busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_out", {out_valid, zero, div_zero, illegal, in_ready}, 0);
    chk("mid.rst_res", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (XLEN + 4) @(negedge clk);
    chk("mid.no_result", out_valid, 0);
    run_op("post_rst_add", 3'b000, 7'h00, 3'b000, 32'd100, 32'd23, 0);

    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 9);
      f7 = 7'h00;
      f3 = 3'b000;
      aop = 3'b000;
      case (k)
        1: f7 = 7'h20;
        2: f3 = 3'b111;
        3: f3 = 3'b110;
        4: f3 = 3'b010;
        5: f7 = 7'h01;
        6: begin f7 = 7'h01; f3 = 3'b100; end
        7: begin aop = 3'b010; f7 = 7'($urandom); f3 = 3'($urandom); end
        8: begin aop = 3'b011; f7 = 7'($urandom); f3 = 3'($urandom); end
        9: begin aop = 3'($urandom); f7 = 7'($urandom); f3 = 3'($urandom); end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), aop, f7, f3, pick(), pick(),
             $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
